// File: rtl/led_pattern_ctrl.sv
// Top-level LED bar driver: debounced mode/speed buttons select one of four
// active-low patterns, stepped by a speed-dependent prescaler.
module led_pattern_ctrl #(
   parameter int BASE_DIV   = 2_097_152,
   parameter int DEB_CYCLES = 500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_mode_n,
   input  logic       key_speed_n,
   output logic [7:0] out,
   output logic [1:0] mode,
   output logic [1:0] speed,
   output logic       step
);

   localparam int PW = $clog2(8 * BASE_DIV);
   localparam int DW = $clog2(DEB_CYCLES + 1);

   typedef enum logic [1:0] {
      SHIFT  = 2'd0,
      BOUNCE = 2'd1,
      FILL   = 2'd2,
      BLINK  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [1:0]    key_raw;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    stable;
   logic [1:0]    press;
   logic [DW-1:0] deb_cnt [2];
   logic          press_mode;
   logic          press_speed;
   logic          any_press;
   logic [PW-1:0] presc;
   logic [PW-1:0] period_m1;
   logic [3:0]    pos;
   logic [3:0]    pos_last;
   logic [2:0]    led_idx;
   logic [7:0]    led_pattern;

   assign key_raw     = {key_speed_n, key_mode_n};
   assign press_mode  = press[0];
   assign press_speed = press[1];
   assign any_press   = press_mode | press_speed;

   // Bit 0 is the mode key, bit 1 the speed key; only a settled 1->0 change yields a press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1  <= 2'b11;
         sync2  <= 2'b11;
         stable <= 2'b11;
         press  <= 2'b00;
         for (int k = 0; k < 2; k++) deb_cnt[k] <= '0;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
         for (int k = 0; k < 2; k++) begin
            press[k] <= 1'b0;
            if (sync2[k] == stable[k]) begin
               deb_cnt[k] <= '0;
            end else if (deb_cnt[k] == DW'(DEB_CYCLES - 1)) begin
               stable[k]  <= sync2[k];
               deb_cnt[k] <= '0;
               press[k]   <= ~sync2[k];
            end else begin
               deb_cnt[k] <= deb_cnt[k] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      period_m1 = PW'(8 * BASE_DIV - 1);
      case (speed)
         2'd0:    period_m1 = PW'(8 * BASE_DIV - 1);
         2'd1:    period_m1 = PW'(4 * BASE_DIV - 1);
         2'd2:    period_m1 = PW'(2 * BASE_DIV - 1);
         default: period_m1 = PW'(BASE_DIV - 1);
      endcase
   end

   // Any press restarts the step interval, so a press and a wrap never both act.
   assign step = (presc == period_m1) && !any_press;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc <= '0;
         speed <= 2'd0;
      end else begin
         if (any_press || presc == period_m1) presc <= '0;
         else                                 presc <= presc + 1'b1;
         if (press_speed) speed <= speed + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= SHIFT;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (press_mode) begin
         case (state)
            SHIFT:   state_next = BOUNCE;
            BOUNCE:  state_next = FILL;
            FILL:    state_next = BLINK;
            default: state_next = SHIFT;
         endcase
      end
   end

   // Pattern decode: pos_last is the final position of the current pattern's cycle.
   always_comb begin
      mode        = state;
      pos_last    = 4'd7;
      led_idx     = pos[2:0];
      led_pattern = 8'hFF;
      case (state)
         SHIFT: begin
            pos_last    = 4'd7;
            led_pattern = ~(8'b1 << pos[2:0]);
         end
         BOUNCE: begin
            pos_last    = 4'd13;
            led_idx     = (pos < 4'd8) ? pos[2:0] : 3'(4'd14 - pos);
            led_pattern = ~(8'b1 << led_idx);
         end
         FILL: begin
            pos_last    = 4'd8;
            led_pattern = 8'hFF << pos;
         end
         default: begin
            pos_last    = 4'd1;
            led_pattern = (pos == 4'd0) ? 8'h00 : 8'hFF;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pos <= 4'd0;
         out <= 8'hFF;
      end else begin
         if (press_mode)            pos <= 4'd0;
         else if (step)             pos <= (pos == pos_last) ? 4'd0 : pos + 4'd1;
         out <= led_pattern;
      end
   end

endmodule
